// File: rtl/md_alu.sv
// md_alu: iterative multiply/divide unit with HI/LO result registers.
// Multiply uses shift-add and divide uses restoring shift-subtract. Both run
// on operand magnitudes for WIDTH cycles, then a single FIX cycle applies the
// sign correction and writes hi/lo. MTHI/MTLO write hi/lo directly from IDLE.
module md_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_bmag;
  // Multiply: {partial product upper half (WIDTH+1 bits), multiplier/lower half}.
  // Divide:   {partial remainder (WIDTH+1 bits), dividend/quotient bits}.
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_in_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [2*WIDTH:0]   w_div_shift;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH:0]   w_div_next;
  logic               w_signed;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Operand magnitudes taken at issue time; signed ops fold negatives positive.
  // The most-negative value maps onto itself, which reads correctly as unsigned.
  always_comb begin
    w_in_signed = (op == OP_MULT) || (op == OP_DIV);
    w_a_mag     = (w_in_signed && A[WIDTH-1]) ? -A : A;
    w_b_mag     = (w_in_signed && B[WIDTH-1]) ? -B : B;
  end

  // One shift-add multiply step and one restoring divide step per CALC cycle.
  always_comb begin
    w_mul_sum   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_bmag} : '0);
    w_mul_next  = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
    w_div_rem   = w_div_shift[2*WIDTH:WIDTH];
    w_div_ge    = (w_div_rem >= {1'b0, r_bmag});
    w_div_diff  = w_div_rem - {1'b0, r_bmag};
    w_div_next  = w_div_ge ? {w_div_diff, w_div_shift[WIDTH-1:1], 1'b1} : w_div_shift;
  end

  // Sign correction and divide-by-zero override applied in the FIX cycle.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_signed   = ~r_op[0];
    w_prod_fix = (w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ?
                 -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    w_quo_fix  = (w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ?
                 -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem_fix  = (w_signed && r_a[WIDTH-1]) ?
                 -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_res_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo   = w_prod_fix[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_b == '0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quo_fix;
      end
    end
  end

  // Control FSM with registered hi/lo/done; reset aborts any operation in flight.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: operand/accumulator registers are deliberately not reset: they are
  // always loaded at issue before being read, so a reset would only add muxing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_op    <= op;
                r_a     <= A;
                r_b     <= B;
                r_bmag  <= w_b_mag;
                r_acc   <= {{(WIDTH+1){1'b0}}, w_a_mag};
                r_cnt   <= '0;
                r_state <= S_CALC;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_alu.md
MD_ALU -- requirements
Module: md_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-006 SHALL have port A  input  WIDTH  operand 1 (multiplicand / dividend / move source).
REQ-007 SHALL have port B  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 SHALL have port busy  output  1  high while an iterative operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse: iterative result written to hi/lo.
REQ-010 SHALL have port hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011 SHALL have port lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; busy = (state != IDLE).
REQ-013 In IDLE with start=1 and op in {MULT,MULTU,DIV,DIVU}: SHALL latch A, B, op and enter CALC with iteration counter = 0.
REQ-014 In IDLE with start=1 and op=MTHI/MTLO: SHALL write A to hi/lo at that edge, stay IDLE, never assert busy or done.
REQ-015 In IDLE with start=1 and op undefined: SHALL take no action.
REQ-016 CALC SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for exactly WIDTH cycles, then enter FIX.
REQ-017 FIX SHALL apply sign correction, write hi/lo at the FIX->IDLE edge, and register done=1 for the following cycle only.
REQ-018 Latency: start sampled at edge 0 -> busy=1 for cycles 1..WIDTH+1 -> done=1 and new hi/lo visible in cycle WIDTH+2 (busy=0 in that cycle).
REQ-019 start while busy=1 SHALL be ignored (any op, including MTHI/MTLO); A/B/op changes while busy SHALL not affect the result.
REQ-020 start in the done cycle SHALL be accepted (back-to-back issue).
REQ-021 MULT: {hi,lo} = signed A * signed B (2*WIDTH-bit two's complement); MULTU: unsigned product.
REQ-022 DIV: lo = quotient truncated toward zero, hi = remainder carrying dividend's sign; DIVU: unsigned quotient/remainder.
REQ-023 Divide by zero (DIV or DIVU): lo = all ones, hi = A; full normal latency.
REQ-024 DIV with A = most-negative, B = -1: lo = most-negative, hi = 0; no other effect.
REQ-025 hi/lo SHALL hold value except on REQ-014 or REQ-017 writes.

Reset
REQ-026 reset=1 at an edge SHALL force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, overriding start.
REQ-027 reset during CALC or FIX SHALL abort the operation: no hi/lo write, no done pulse.

Verification (WIDTH=32)
REQ-028 MULT A=0xFFFFFFFE, B=0x00000003 -> done in cycle 34 after start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-029 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=100, B=7 -> lo=14, hi=2.
REQ-030 DIVU A=0x12345678, B=0 -> lo=0xFFFFFFFF, hi=0x12345678; DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 MULTU started, then start with MTHI A=0xDEADBEEF at cycle 5 -> ignored; hi = product upper half at done; MTHI issued in done cycle -> hi=0xDEADBEEF next cycle, busy stays 0.
REQ-032 DIV started, reset pulsed at cycle 10 -> busy=0, hi=lo=0 next cycle, no done pulse within 40 cycles.
REQ-033 Back-to-back: MULT issued in done cycle of prior DIV -> second done exactly 34 cycles later, first result intact until then.
